// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and memory-side bundle for mem_arbiter
// Purpose : groups the IF requester, LS requester and memory bus signals.
// Modports: slave  - arbiter side (takes requests and read data, drives memory bus)
//           master - environment side (requesters and memory model)
interface mem_arbiter_if;
   logic        IF_req_valid;
   logic [31:0] IF_req_addr;
   logic        IF_req_ready;
   logic        IF_rsp_valid;
   logic [31:0] IF_rsp_data;
   logic        IF_rsp_err;

   logic        LS_req_valid;
   logic        LS_req_write;
   logic [1:0]  LS_req_length;
   logic        LS_req_signed;
   logic [31:0] LS_req_addr;
   logic [31:0] LS_req_wdata;
   logic        LS_req_ready;
   logic        LS_rsp_valid;
   logic [31:0] LS_rsp_data;
   logic        LS_rsp_err;

   logic [31:0] MEM_address;
   logic [1:0]  MEM_write_length;
   logic [1:0]  MEM_read_length;
   logic        MEM_read_signed;
   logic [31:0] MEM_write_data;
   logic [31:0] MEM_read_data;

   modport slave (
      input  IF_req_valid, IF_req_addr,
      output IF_req_ready, IF_rsp_valid, IF_rsp_data, IF_rsp_err,
      input  LS_req_valid, LS_req_write, LS_req_length, LS_req_signed, LS_req_addr, LS_req_wdata,
      output LS_req_ready, LS_rsp_valid, LS_rsp_data, LS_rsp_err,
      output MEM_address, MEM_write_length, MEM_read_length, MEM_read_signed, MEM_write_data,
      input  MEM_read_data
   );

   modport master (
      output IF_req_valid, IF_req_addr,
      input  IF_req_ready, IF_rsp_valid, IF_rsp_data, IF_rsp_err,
      output LS_req_valid, LS_req_write, LS_req_length, LS_req_signed, LS_req_addr, LS_req_wdata,
      input  LS_req_ready, LS_rsp_valid, LS_rsp_data, LS_rsp_err,
      input  MEM_address, MEM_write_length, MEM_read_length, MEM_read_signed, MEM_write_data,
      output MEM_read_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (IF/LS) single-outstanding memory arbiter
// Purpose : arbitrates instruction-fetch and load/store requests onto one memory
//           port, LS priority with IF starvation guard, IDLE -> ACCESS -> RESP.
// Ports   : SYS_clk      - clock, rising edge
//           SYS_reset_n  - asynchronous active-low reset
//           bus          - mem_arbiter_if.slave (IF/LS request+response, memory bus)
// Params  : MEM_LATENCY (1..15) read-data delay, STARVE_LIMIT (1..15) LS streak cap
// Option  : MEM_ALIGN_CHECK_EN - reject misaligned accesses with rsp_err instead of
//           issuing them to memory.
module mem_arbiter #(
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         SYS_clk,
   input  logic         SYS_reset_n,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] LAST_ACC   = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [3:0]  r_streak;
   logic        r_ls;
   logic        r_wr;
   logic        r_sgn;
   logic        r_err;
   logic [1:0]  r_len;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;

   logic        w_idle;
   logic        w_if_wins;
   logic        w_if_gnt;
   logic        w_ls_gnt;
   logic        w_misaligned;
   logic [31:0] w_hs_addr;
   logic [1:0]  w_hs_len;
   logic        w_acc;
   logic        w_resp;
   logic        w_rd;
   logic        w_wr_issue;

   // Ready is gated by reset so every output reads 0 while reset is held.
   assign w_idle    = (r_state == IDLE) && SYS_reset_n;
   assign w_if_wins = bus.IF_req_valid && (!bus.LS_req_valid || (r_streak == STREAK_MAX));
   assign w_if_gnt  = w_idle && w_if_wins;
   assign w_ls_gnt  = w_idle && bus.LS_req_valid && !w_if_wins;

   // IF fetches are always word reads, so treat them as length 11.
   assign w_hs_addr = w_if_gnt ? bus.IF_req_addr : bus.LS_req_addr;
   assign w_hs_len  = w_if_gnt ? 2'b11 : bus.LS_req_length;

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      w_misaligned = 1'b0;
      case (w_hs_len)
         2'b10:   w_misaligned = w_hs_addr[0];
         2'b11:   w_misaligned = |w_hs_addr[1:0];
         default: w_misaligned = 1'b0;
      endcase
   end
`else
   assign w_misaligned = 1'b0;
`endif

   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_streak <= '0;
         r_ls     <= 1'b0;
         r_wr     <= 1'b0;
         r_sgn    <= 1'b0;
         r_err    <= 1'b0;
         r_len    <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_if_gnt || w_ls_gnt) begin
                  r_ls    <= w_ls_gnt;
                  r_wr    <= w_ls_gnt && bus.LS_req_write;
                  r_sgn   <= w_ls_gnt && bus.LS_req_signed;
                  r_len   <= w_hs_len;
                  r_addr  <= w_hs_addr;
                  r_wdata <= bus.LS_req_wdata;
                  r_cnt   <= '0;
                  r_err   <= w_misaligned;
                  r_rdata <= '0;
                  // A rejected access answers straight away, skipping memory.
                  r_state <= w_misaligned ? RESP : ACCESS;
                  // Streak counts LS wins only while IF is actually waiting.
                  if (w_ls_gnt && bus.IF_req_valid) begin
                     if (r_streak != STREAK_MAX) r_streak <= r_streak + 4'd1;
                  end else begin
                     r_streak <= '0;
                  end
               end
            end
            ACCESS: begin
               if (r_cnt == LAST_ACC) begin
                  r_rdata <= r_wr ? 32'd0 : bus.MEM_read_data;
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_acc      = (r_state == ACCESS);
   assign w_resp     = (r_state == RESP);
   assign w_rd       = w_acc && !r_wr;
   // Writes are a single-cycle strobe in the first ACCESS cycle.
   assign w_wr_issue = w_acc && r_wr && (r_cnt == 4'd0);

   assign bus.MEM_address      = w_acc ? r_addr : 32'd0;
   assign bus.MEM_read_length  = w_rd ? r_len : 2'b00;
   assign bus.MEM_read_signed  = w_rd && r_sgn;
   assign bus.MEM_write_length = w_wr_issue ? r_len : 2'b00;
   assign bus.MEM_write_data   = w_wr_issue ? r_wdata : 32'd0;

   assign bus.IF_req_ready = w_if_gnt;
   assign bus.LS_req_ready = w_ls_gnt;

   // r_err can only be set when alignment checking is built in.
   assign bus.IF_rsp_valid = w_resp && !r_ls;
   assign bus.IF_rsp_data  = bus.IF_rsp_valid ? r_rdata : 32'd0;
   assign bus.IF_rsp_err   = bus.IF_rsp_valid && r_err;
   assign bus.LS_rsp_valid = w_resp && r_ls;
   assign bus.LS_rsp_data  = bus.LS_rsp_valid ? r_rdata : 32'd0;
   assign bus.LS_rsp_err   = bus.LS_rsp_valid && r_err;
endmodule
